// File: rtl/perf_monitor_if.sv
// Control and counter bundle between the pipeline harness and perf_monitor.
// master drives the event strobes; slave (the monitor) returns the counters and state.
interface perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             clear_i;
  logic             stall_i;
  logic             branch_i;
  logic             flush_i;
  logic             retire_i;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic [1:0]       state_o;
  logic             halt_o;

  modport master (
    output start_i, clear_i, stall_i, branch_i, flush_i, retire_i,
    input  cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o, state_o, halt_o
  );

  modport slave (
    input  start_i, clear_i, stall_i, branch_i, flush_i, retire_i,
    output cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o, state_o, halt_o
  );
endinterface

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: saturating event counters plus a run/done/timeout FSM.
// Counts are visible one cycle after the event; no backpressure, every cycle is sampled.
module perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 64,
  parameter int IDLE_WINDOW = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  perf_monitor_if.slave         bus
);
  localparam int RW = $clog2(MAX_CYCLES + 1);
  localparam int IW = $clog2(IDLE_WINDOW + 1);
  localparam logic [RW-1:0] RUN_LIM  = RW'(MAX_CYCLES);
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_WINDOW);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [RW-1:0]    run_q, run_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             armed_q, armed_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    retire_d = retire_q;
    run_d    = run_q;
    idle_d   = idle_q;
    armed_d  = armed_q;
    if (bus.clear_i) begin
      state_d  = IDLE;
      cyc_d    = '0;
      stall_d  = '0;
      flush_d  = '0;
      retire_d = '0;
      run_d    = '0;
      idle_d   = '0;
      armed_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) state_d = RUN;
        end
        RUN: begin
          cyc_d = sat_inc(cyc_q);
          if (bus.stall_i && !bus.branch_i) stall_d = sat_inc(stall_q);
          if (bus.flush_i)  flush_d  = sat_inc(flush_q);
          if (bus.retire_i) retire_d = sat_inc(retire_q);
          // run_q never saturates, so the cycle limit still fires once the visible counter has capped
          run_d = run_q + RW'(1);
          if (bus.retire_i) begin
            idle_d  = '0;
            armed_d = 1'b1;
          end else if (armed_q) begin
            idle_d = idle_q + IW'(1);
          end
          if (run_d == RUN_LIM) begin
            state_d = TIMEOUT;
          end else if (armed_q && !bus.retire_i && idle_d == IDLE_LIM) begin
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
      run_q    <= '0;
      idle_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      retire_q <= retire_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.cycle_cnt_o  = cyc_q;
  assign bus.stall_cnt_o  = stall_q;
  assign bus.flush_cnt_o  = flush_q;
  assign bus.retire_cnt_o = retire_q;
  assign bus.state_o      = state_q;
  assign bus.halt_o       = (state_q == DONE) || (state_q == TIMEOUT);
endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: default-sized instance plus a 4-bit, 40-cycle instance.
module tb_perf_monitor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  perf_monitor_if #(.CNT_W(32)) a_if ();
  perf_monitor_if #(.CNT_W(4))  b_if ();

  perf_monitor #(.CNT_W(32), .MAX_CYCLES(64), .IDLE_WINDOW(8)) u_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (a_if)
  );

  perf_monitor #(.CNT_W(4), .MAX_CYCLES(40), .IDLE_WINDOW(8)) u_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_idle_inputs();
    a_if.start_i  = 1'b0;
    a_if.clear_i  = 1'b0;
    a_if.stall_i  = 1'b0;
    a_if.branch_i = 1'b0;
    a_if.flush_i  = 1'b0;
    a_if.retire_i = 1'b0;
  endtask

  task automatic a_clear();
    a_idle_inputs();
    a_if.clear_i = 1'b1;
    tick(1);
    a_if.clear_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a_idle_inputs();
    b_if.start_i  = 1'b0;
    b_if.clear_i  = 1'b0;
    b_if.stall_i  = 1'b0;
    b_if.branch_i = 1'b0;
    b_if.flush_i  = 1'b0;
    b_if.retire_i = 1'b0;

    #3;
    check("rst_state", a_if.state_o, 0);
    check("rst_cycle", a_if.cycle_cnt_o, 0);
    check("rst_halt", a_if.halt_o, 0);
    #9 rst_n = 1'b1;
    tick(2);
    check("idle_wait", a_if.state_o, 0);

    // clear wins over start in IDLE
    a_if.start_i = 1'b1;
    a_if.clear_i = 1'b1;
    tick(1);
    check("clr_over_start", a_if.state_o, 0);
    a_if.clear_i = 1'b0;

    // Timeout with retire every cycle; start drops after entering RUN
    a_if.retire_i = 1'b1;
    tick(1);
    check("to_enter_run", a_if.state_o, 1);
    check("to_no_count_entry", a_if.cycle_cnt_o, 0);
    a_if.start_i = 1'b0;
    tick(63);
    check("to_run63", a_if.state_o, 1);
    check("to_cycle63", a_if.cycle_cnt_o, 63);
    tick(1);
    check("to_state", a_if.state_o, 3);
    check("to_cycle", a_if.cycle_cnt_o, 64);
    check("to_retire", a_if.retire_cnt_o, 64);
    check("to_halt", a_if.halt_o, 1);
    tick(3);
    check("to_hold_cycle", a_if.cycle_cnt_o, 64);
    check("to_hold_state", a_if.state_o, 3);
    a_clear();
    check("clr_state", a_if.state_o, 0);
    check("clr_halt", a_if.halt_o, 0);
    check("clr_cycle", a_if.cycle_cnt_o, 0);
    check("clr_retire", a_if.retire_cnt_o, 0);

    // DONE 8 cycles after the last of 10 retires
    a_if.start_i = 1'b1;
    tick(1);
    a_if.start_i  = 1'b0;
    a_if.retire_i = 1'b1;
    tick(10);
    a_if.retire_i = 1'b0;
    tick(7);
    check("done_not_yet", a_if.state_o, 1);
    tick(1);
    check("done_state", a_if.state_o, 2);
    check("done_cycle", a_if.cycle_cnt_o, 18);
    check("done_retire", a_if.retire_cnt_o, 10);
    check("done_halt", a_if.halt_o, 1);
    a_clear();
    check("done_clr_state", a_if.state_o, 0);
    check("done_clr_halt", a_if.halt_o, 0);

    // Stall qualification by branch, flush overlapping stalls
    a_if.start_i = 1'b1;
    tick(1);
    a_if.start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_if.stall_i  = 1'b1;
      a_if.branch_i = (i >= 5);
      a_if.flush_i  = (i < 3);
      tick(1);
    end
    a_idle_inputs();
    check("stall_cnt", a_if.stall_cnt_o, 5);
    check("flush_cnt", a_if.flush_cnt_o, 3);
    check("sf_cycle", a_if.cycle_cnt_o, 7);
    check("sf_retire", a_if.retire_cnt_o, 0);
    a_clear();

    // Unarmed RUN must not reach DONE during pipeline fill
    a_if.start_i = 1'b1;
    tick(1);
    a_if.start_i = 1'b0;
    tick(20);
    check("unarmed_run", a_if.state_o, 1);
    check("unarmed_cycle", a_if.cycle_cnt_o, 20);
    a_if.retire_i = 1'b1;
    tick(1);
    a_if.retire_i = 1'b0;
    tick(7);
    check("armed_not_yet", a_if.state_o, 1);
    tick(1);
    check("armed_done", a_if.state_o, 2);
    check("armed_cycle", a_if.cycle_cnt_o, 29);
    check("armed_retire", a_if.retire_cnt_o, 1);
    a_clear();

    // DONE and TIMEOUT on the same edge: TIMEOUT wins
    a_if.start_i = 1'b1;
    tick(1);
    a_if.start_i  = 1'b0;
    a_if.retire_i = 1'b1;
    tick(56);
    a_if.retire_i = 1'b0;
    tick(7);
    check("tie_run", a_if.state_o, 1);
    tick(1);
    check("tie_timeout", a_if.state_o, 3);
    check("tie_retire", a_if.retire_cnt_o, 56);
    a_clear();

    // Asynchronous reset mid-RUN
    a_if.start_i  = 1'b1;
    a_if.retire_i = 1'b1;
    tick(1);
    tick(5);
    check("pre_rst_cycle", a_if.cycle_cnt_o, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", a_if.state_o, 0);
    check("arst_cycle", a_if.cycle_cnt_o, 0);
    check("arst_retire", a_if.retire_cnt_o, 0);
    check("arst_halt", a_if.halt_o, 0);
    #1 rst_n = 1'b1;
    a_idle_inputs();
    tick(3);
    check("post_rst_idle", a_if.state_o, 0);
    check("post_rst_cycle", a_if.cycle_cnt_o, 0);

    // 4-bit counters saturate while the uncapped run count still times out
    b_if.stall_i = 1'b1;
    b_if.start_i = 1'b1;
    tick(1);
    b_if.start_i = 1'b0;
    tick(15);
    check("sat_stall15", b_if.stall_cnt_o, 15);
    check("sat_cycle15", b_if.cycle_cnt_o, 15);
    tick(10);
    check("sat_stall_hold", b_if.stall_cnt_o, 15);
    check("sat_cycle_hold", b_if.cycle_cnt_o, 15);
    check("sat_run", b_if.state_o, 1);
    tick(14);
    check("sat_run39", b_if.state_o, 1);
    tick(1);
    check("sat_timeout", b_if.state_o, 3);
    check("sat_halt", b_if.halt_o, 1);
    check("sat_cycle_final", b_if.cycle_cnt_o, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of every event counter.
REQ-002 Parameter MAX_CYCLES, default 64, run-cycle limit before forced stop.
REQ-003 Parameter IDLE_WINDOW, default 8, consecutive non-retiring run cycles that declare the program finished.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  CPU start; level, sampled each cycle.
REQ-007 clear_i  in  1  synchronous clear of counters and state machine.
REQ-008 stall_i  in  1  hazard-detection stall request this cycle.
REQ-009 branch_i  in  1  decode-stage branch flag; a stall qualified by it is not counted.
REQ-010 flush_i  in  1  IF/ID flush this cycle.
REQ-011 retire_i  in  1  MEM/WB stage holds a valid instruction this cycle.
REQ-012 cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o  out  CNT_W each  event counts.
REQ-013 state_o  out  2  IDLE=0, RUN=1, DONE=2, TIMEOUT=3.
REQ-014 halt_o  out  1  high in DONE or TIMEOUT; testbench stops on it.

Function
REQ-015 FSM: IDLE -> RUN on start_i=1; RUN -> DONE when idle-run counter reaches IDLE_WINDOW; RUN -> TIMEOUT when cycle_cnt_o reaches MAX_CYCLES; DONE and TIMEOUT held until clear_i or reset.
REQ-016 If DONE and TIMEOUT conditions hold in the same cycle, TIMEOUT wins.
REQ-017 start_i deasserting in RUN leaves state RUN; start_i ignored outside IDLE.
REQ-018 Counters update only in RUN, including the cycle that transitions out of RUN; the IDLE->RUN cycle counts nothing.
REQ-019 cycle_cnt_o +1 per RUN cycle.
REQ-020 stall_cnt_o +1 per RUN cycle with stall_i=1 and branch_i=0.
REQ-021 flush_cnt_o +1 per RUN cycle with flush_i=1; independent of stall_i (both may count same cycle).
REQ-022 retire_cnt_o +1 per RUN cycle with retire_i=1.
REQ-023 All counters saturate at 2^CNT_W-1; no wrap.
REQ-024 Internal idle-run counter (width clog2(IDLE_WINDOW+1)): +1 per RUN cycle with retire_i=0, reset to 0 on retire_i=1; compare uses post-increment value, so IDLE_WINDOW consecutive zero cycles enter DONE on the edge ending the last one.
REQ-025 Idle-run counter is not armed until first retire_i=1 in RUN (pipeline fill must not trigger DONE); before arming, only TIMEOUT can end RUN.
REQ-026 clear_i=1: next edge sets all counters, idle-run counter, arm flag to 0 and state to IDLE; clear_i overrides every other input that cycle.
REQ-027 halt_o combinational from registered state; no other output depends combinationally on inputs.
REQ-028 All outputs are direct register values or decodes of registers; counter values visible the cycle after the counted event.

Reset
REQ-029 rst_i=0 asynchronously forces state IDLE, all counters 0, idle-run counter 0, arm flag 0, halt_o 0, independent of clk_i.
REQ-030 Reset asserted mid-RUN discards counts; after release block waits in IDLE for start_i.
REQ-031 Release of rst_i synchronised by the environment; first counted edge is the one after IDLE->RUN.

Verification
REQ-032 Reset then start_i=1, retire_i=1 every cycle, MAX_CYCLES=64 -> TIMEOUT after 64 RUN cycles, cycle_cnt_o=64, retire_cnt_o=64, halt_o=1.
REQ-033 Start, retire_i=1 for 10 cycles then 0 -> DONE exactly 8 cycles after last retire; cycle_cnt_o=18, retire_cnt_o=10.
REQ-034 Start, 5 cycles stall_i=1 with branch_i=0, 2 cycles stall_i=1 with branch_i=1, 3 cycles flush_i=1 overlapped with stalls -> stall_cnt_o=5, flush_cnt_o=3.
REQ-035 Start, retire_i=0 for 20 cycles -> stays RUN (unarmed), no DONE; then retire_i pulse and 8 zeros -> DONE.
REQ-036 CNT_W=4, MAX_CYCLES=40, stall_i=1 always -> stall_cnt_o and cycle_cnt_o hold 15 once saturated; TIMEOUT still reached via internal compare (cycle limit compare uses an uncapped run counter of width clog2(MAX_CYCLES+1)).
REQ-037 rst_i pulsed low mid-RUN between clock edges -> outputs zero immediately; clear_i in DONE -> IDLE next edge, halt_o=0.
